// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
// Shared definitions for the iterative signed multiply/divide unit:
//   - FSM state encoding (idle / busy / done)
//   - iteration count for one operation
//   - operation type encoding (multiply / divide)
// -----------------------------------------------------------------------------
package multdiv_pkg;

    // One iteration per operand bit.
    localparam int N_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

endpackage : multdiv_pkg

// File: rtl/multdiv_seq_iter_step.sv
// -----------------------------------------------------------------------------
// md_iter_step
// Combinational single iteration of the multiply/divide datapath, operating on
// unsigned magnitudes held in a {hi, lo} register pair.
//
// Ports:
//   op_i    : operation type (OP_MUL / OP_DIV)
//   opnd_i  : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   hi_i    : upper half - partial product (multiply) or remainder (divide)
//   lo_i    : lower half - remaining multiplier bits (multiply) or
//             dividend bits / growing quotient (divide)
//   hi_o    : next upper half
//   lo_o    : next lower half
// -----------------------------------------------------------------------------
module md_iter_step
    import multdiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  op_e               op_i,
    input  logic [DATA_W-1:0] opnd_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W:0]   sum_s;       // partial product plus optional multiplicand, with carry
    logic [DATA_W:0]   shl_s;       // remainder shifted left with next dividend bit
    logic [DATA_W+1:0] diff_s;      // trial subtraction; MSB is the borrow
    logic              unused_diff_s;

    // Datapath for one shift-add or one restoring-divide iteration.
    always_comb begin
        if (lo_i[0]) begin
            sum_s = {1'b0, hi_i} + {1'b0, opnd_i};
        end else begin
            sum_s = {1'b0, hi_i};
        end

        shl_s  = {hi_i, lo_i[DATA_W-1]};
        diff_s = {1'b0, shl_s} - {2'b00, opnd_i};
        // The remainder stays below the divisor, so bit DATA_W of a
        // successful subtraction is always zero.
        unused_diff_s = diff_s[DATA_W];

        case (op_i)
            OP_MUL: begin
                // Carry of the add drops into the top bit as the pair shifts right.
                hi_o = sum_s[DATA_W:1];
                lo_o = {sum_s[0], lo_i[DATA_W-1:1]};
            end
            OP_DIV: begin
                if (diff_s[DATA_W+1]) begin
                    // Borrow: restore the shifted remainder, quotient bit 0.
                    // A set shl_s[DATA_W] can never borrow, so dropping it is safe.
                    hi_o = shl_s[DATA_W-1:0];
                    lo_o = {lo_i[DATA_W-2:0], 1'b0};
                end else begin
                    hi_o = diff_s[DATA_W-1:0];
                    lo_o = {lo_i[DATA_W-2:0], 1'b1};
                end
            end
            default: begin
                hi_o = hi_i;
                lo_o = lo_i;
            end
        endcase
    end

endmodule : md_iter_step

// File: rtl/multdiv_seq.sv
// -----------------------------------------------------------------------------
// multdiv_seq
// Iterative signed 32-bit multiply/divide unit with fixed 33-cycle latency.
// A start pulse (ctrl_MULT or ctrl_DIV, multiply wins if both) in IDLE or DONE
// latches operand magnitudes and signs; 32 BUSY cycles follow, then one DONE
// cycle with data_resultRDY high. Results hold until the next completion.
//
// Ports:
//   clock          : master clock
//   reset          : synchronous active-high reset; aborts any operation
//   data_operandA  : multiplicand / dividend (sampled on start only)
//   data_operandB  : multiplier / divisor (sampled on start only)
//   ctrl_MULT      : start-multiply pulse
//   ctrl_DIV       : start-divide pulse
//   data_result    : low product word, or quotient
//   data_exception : signed overflow or divide-by-zero
//   data_resultRDY : one-cycle completion pulse
//   running        : high while the operation iterates
// -----------------------------------------------------------------------------
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              running
);

    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(N_ITER - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ZERO = CNT_W'(0);
    localparam logic [DATA_W-1:0]   ONE_W    = DATA_W'(1);
    localparam logic [DATA_W-1:0]   ZERO_W   = DATA_W'(0);
    localparam logic [2*DATA_W-1:0] ONE_2W   = (2*DATA_W)'(1);

    // Registers
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic              sign_q, sign_d;         // result sign A[msb]^B[msb]
    logic              dvd_neg_q, dvd_neg_d;   // dividend was negative
    logic [DATA_W-1:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              exc_q, exc_d;
    logic              rdy_q, rdy_d;
    logic              running_q, running_d;

    // Combinational helpers
    logic              start_s;
    logic [DATA_W-1:0] mag_a_s, mag_b_s;
    logic [DATA_W-1:0] step_hi_s, step_lo_s;
    logic [2*DATA_W-1:0] prod_s, sprod_s;
    logic [DATA_W:0]   ovf_bits_s;
    logic              mul_exc_s;
    logic              div_zero_s;
    logic [DATA_W-1:0] div_res_s;
    logic              div_exc_s;
    logic [DATA_W-1:0] fin_res_s;
    logic              fin_exc_s;

    md_iter_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .op_i   (op_q),
        .opnd_i (opnd_q),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .hi_o   (step_hi_s),
        .lo_o   (step_lo_s)
    );

    // Operand magnitudes; 0x80000000 maps to 2^31, which is exact as unsigned.
    always_comb begin
        if (data_operandA[DATA_W-1]) begin
            mag_a_s = ~data_operandA + ONE_W;
        end else begin
            mag_a_s = data_operandA;
        end
        if (data_operandB[DATA_W-1]) begin
            mag_b_s = ~data_operandB + ONE_W;
        end else begin
            mag_b_s = data_operandB;
        end
    end

    // Sign correction and exception detection on the final iteration's output.
    always_comb begin
        prod_s = {step_hi_s, step_lo_s};
        if (sign_q) begin
            sprod_s = ~prod_s + ONE_2W;
        end else begin
            sprod_s = prod_s;
        end
        // The signed product fits in DATA_W bits only if its upper bits
        // replicate the result sign bit.
        ovf_bits_s = sprod_s[2*DATA_W-1:DATA_W-1];
        mul_exc_s  = ~((&ovf_bits_s) | ~(|ovf_bits_s));

        div_zero_s = (opnd_q == ZERO_W);
        if (div_zero_s) begin
            div_res_s = ZERO_W;
            div_exc_s = 1'b1;
        end else begin
            if (sign_q) begin
                div_res_s = ~step_lo_s + ONE_W;
            end else begin
                div_res_s = step_lo_s;
            end
            // A quotient magnitude of 2^31 only arises from a -2^31 dividend;
            // it is representable only when the result is negative.
            div_exc_s = dvd_neg_q & ~sign_q & step_lo_s[DATA_W-1];
        end

        case (op_q)
            OP_MUL: begin
                fin_res_s = sprod_s[DATA_W-1:0];
                fin_exc_s = mul_exc_s;
            end
            OP_DIV: begin
                fin_res_s = div_res_s;
                fin_exc_s = div_exc_s;
            end
            default: begin
                fin_res_s = sprod_s[DATA_W-1:0];
                fin_exc_s = mul_exc_s;
            end
        endcase
    end

    // Next-state, datapath-load and output logic.
    always_comb begin
        start_s   = ctrl_MULT | ctrl_DIV;
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sign_d    = sign_q;
        dvd_neg_d = dvd_neg_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        running_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    state_d   = ST_BUSY;
                    running_d = 1'b1;
                    cnt_d     = CNT_ZERO;
                    sign_d    = data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
                    dvd_neg_d = data_operandA[DATA_W-1];
                    hi_d      = ZERO_W;
                    if (ctrl_MULT) begin
                        op_d   = OP_MUL;
                        opnd_d = mag_a_s;
                        lo_d   = mag_b_s;
                    end else begin
                        op_d   = OP_DIV;
                        opnd_d = mag_b_s;
                        lo_d   = mag_a_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Start pulses are ignored here.
                hi_d  = step_hi_s;
                lo_d  = step_lo_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d  = ST_DONE;
                    rdy_d    = 1'b1;
                    result_d = fin_res_s;
                    exc_d    = fin_exc_s;
                end else begin
                    running_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, datapath and registered output flops with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            op_q      <= OP_MUL;
            sign_q    <= 1'b0;
            dvd_neg_q <= 1'b0;
            opnd_q    <= ZERO_W;
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
            result_q  <= ZERO_W;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sign_q    <= sign_d;
            dvd_neg_q <= dvd_neg_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
            running_q <= running_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign running        = running_q;

endmodule : multdiv_seq

// File: tb/tb_multdiv_seq.sv
// -----------------------------------------------------------------------------
// tb_multdiv_seq
// Self-checking bench for multdiv_seq: a table of directed multiply/divide
// vectors with hand-computed results, followed by hand-written sequences for
// ignored start pulses, back-to-back restart and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_multdiv_seq;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        running;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] held_res;
    logic        held_exc;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[18];

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .running        (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered at a negedge with no start pending. Pulses the start, then checks
    // running/RDY/held outputs for cycles 1..32 and the results in cycle 33.
    // Returns positioned in the RDY cycle. inj_k > 0 pulses ctrl_DIV in that
    // busy cycle.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r,
                          input logic exp_e, input int inj_k, input string name);
        logic ok;
        ok = 1'b1;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        for (int k = 1; k <= 32; k++) begin
            if (k == inj_k) begin
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd100;
                data_operandB = 32'd7;
            end else begin
                ctrl_DIV = 1'b0;
            end
            if (running !== 1'b1 || data_resultRDY !== 1'b0 ||
                data_result !== held_res || data_exception !== held_exc) begin
                ok = 1'b0;
            end
            @(negedge clock);
        end
        ctrl_DIV = 1'b0;
        check({name, " busy"},    {31'd0, ok},             32'd1);
        check({name, " rdy"},     {31'd0, data_resultRDY}, 32'd1);
        check({name, " running"}, {31'd0, running},        32'd0);
        check({name, " result"},  data_result,             exp_r);
        check({name, " exc"},     {31'd0, data_exception}, {31'd0, exp_e});
        held_res = exp_r;
        held_exc = exp_e;
    endtask

    // Idle for n cycles; no RDY, not running, outputs holding.
    task automatic idle(input int n, input string name);
        logic ok;
        ok = 1'b1;
        repeat (n) begin
            @(negedge clock);
            if (running !== 1'b0 || data_resultRDY !== 1'b0 ||
                data_result !== held_res || data_exception !== held_exc) begin
                ok = 1'b0;
            end
        end
        check({name, " idle hold"}, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        //            m     d     A              B              result         exc
        vecs[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'd0,        32'h12345678, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd15,        1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 32'd6,        32'd7,        32'd42,        1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'h00000000, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd14,        1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h80000000, 32'd2,        32'hC0000000, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'd3,        32'd10,       32'h00000000, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,        1'b0};
        vecs[16] = '{1'b0, 1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd0,        32'h00000000, 1'b1};

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        held_res      = 32'd0;
        held_exc      = 1'b0;

        repeat (3) @(negedge clock);
        check("reset result",  data_result,             32'd0);
        check("reset exc",     {31'd0, data_exception}, 32'd0);
        check("reset rdy",     {31'd0, data_resultRDY}, 32'd0);
        check("reset running", {31'd0, running},        32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven vectors with a short idle gap between them.
        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].exc, 0, $sformatf("vec%0d", i));
            idle(2, $sformatf("vec%0d", i));
        end

        // ctrl_DIV pulsed in busy cycle 10 of a multiply is ignored.
        run_op(1'b1, 1'b0, 32'd1234, 32'd1000, 32'd1234000, 1'b0, 10, "ignore_div");
        idle(40, "ignore_div no second rdy");

        // Restart a divide in the RDY cycle of a multiply: RDY again in cycle 66.
        run_op(1'b1, 1'b0, 32'd9, 32'd9, 32'd81, 1'b0, 0, "b2b mul");
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 0, "b2b div");
        idle(5, "b2b");

        // Reset in busy cycle 15 aborts with no RDY.
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (14) @(negedge clock);
        check("pre-reset running", {31'd0, running}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("abort result",  data_result,             32'd0);
        check("abort exc",     {31'd0, data_exception}, 32'd0);
        check("abort rdy",     {31'd0, data_resultRDY}, 32'd0);
        check("abort running", {31'd0, running},        32'd0);
        reset    = 1'b0;
        held_res = 32'd0;
        held_exc = 1'b0;
        idle(40, "abort");
        run_op(1'b1, 1'b0, 32'd3, 32'd3, 32'd9, 1'b0, 0, "post-reset mul");
        idle(3, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_multdiv_seq
